instruction_buffer_dual: RTL



---
 rtl/instruction_buffer_dual_pkg.sv | 86 ++++++++
 rtl/instruction_buffer_dual_if.sv | 61 ++++++
 rtl/instruction_buffer_dual_ram.sv | 45 ++++
 rtl/instruction_buffer_dual.sv | 117 +++++++++++
 4 files changed

// File: rtl/instruction_buffer_dual_pkg.sv
// ---------------------------------------------------------------------------
// instruction_buffer_dual_pkg
//   Shared core definitions for the fetch -> decode instruction queue.
//   Holds the default queue geometry, the entry payload layout (field
//   offsets and fault bit positions) used by fetch to pack and by decode to
//   unpack an entry, and small helpers. The queue itself treats the payload
//   as opaque bits.
// ---------------------------------------------------------------------------
package instruction_buffer_dual_pkg;

    // Default queue geometry
    localparam int unsigned IB_WIDTH   = 102;
    localparam int unsigned IB_DEPTH   = 32;
    localparam int unsigned IB_DEPTH_N = 5;
    localparam int unsigned IB_STOP_TH = 26;

    // Entry payload layout (LSB first)
    localparam int unsigned PC_LSB      = 0;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned INST_LSB    = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned PADDR_LSB   = 64;
    localparam int unsigned PADDR_W     = 32;
    localparam int unsigned PREDICT_BIT = 96;
    localparam int unsigned KERNEL_BIT  = 97;
    localparam int unsigned PAGING_BIT  = 98;
    localparam int unsigned FAULT_LSB   = 99;
    localparam int unsigned FAULT_W     = 3;

    // Bit positions inside the 3-bit fault field
    localparam int unsigned FAULT_BIT_PAGE  = 0;
    localparam int unsigned FAULT_BIT_PRIV  = 1;
    localparam int unsigned FAULT_BIT_ALIGN = 2;

    // Packed view of one entry; member order matches the offsets above
    typedef struct packed {
        logic [FAULT_W-1:0] fault;
        logic               paging;
        logic               kernel;
        logic               predict;
        logic [PADDR_W-1:0] predictAddr;
        logic [INST_W-1:0]  inst;
        logic [PC_W-1:0]    pc;
    } ib_entry_t;

    // Lane masks shared by the write and read sides
    localparam logic [1:0] LANES_NONE = 2'b00;
    localparam logic [1:0] LANES_ONE  = 2'b01;
    localparam logic [1:0] LANES_TWO  = 2'b11;

    function automatic logic [IB_WIDTH-1:0] pack_entry(
        input logic [FAULT_W-1:0] fault,
        input logic               paging,
        input logic               kernel,
        input logic               predict,
        input logic [PADDR_W-1:0] predictAddr,
        input logic [INST_W-1:0]  inst,
        input logic [PC_W-1:0]    pc
    );
        ib_entry_t e;
        e.fault       = fault;
        e.paging      = paging;
        e.kernel      = kernel;
        e.predict     = predict;
        e.predictAddr = predictAddr;
        e.inst        = inst;
        e.pc          = pc;
        return e;
    endfunction

    function automatic logic [PC_W-1:0] entry_pc(input logic [IB_WIDTH-1:0] entry);
        return entry[PC_LSB +: PC_W];
    endfunction

    // Number of lanes a write mask asks for; the unsupported mask 2'b10 asks for none
    function automatic logic [1:0] lane_count(input logic [1:0] mask);
        logic [1:0] n;
        case (mask)
            LANES_TWO: n = 2'd2;
            LANES_ONE: n = 2'd1;
            default:   n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/instruction_buffer_dual_if.sv
// ---------------------------------------------------------------------------
// instruction_buffer_dual_if
//   Fetch-side and decode-side signals of the dual instruction queue.
//   master : the fetch/decode pair driving the queue
//            (drives iPREVIOUS_*, iNEXT_READ; sees flags, data, count)
//   slave  : the queue itself
//   Signals
//     iPREVIOUS_INST_VALID [1:0]  write lanes (00 none, 01 lane0, 11 both)
//     iPREVIOUS_DATA0/1           older / younger incoming entry
//     oPREVIOUS_LOCK              fewer than two free slots, writes dropped
//     oPREVIOUS_FETCH_STOP        occupancy above stop threshold
//     oNEXT_INST_VALID [1:0]      [0] count>=1, [1] count>=2
//     oNEXT_DATA0/1               head / head+1 entry (show-ahead)
//     iNEXT_READ [1:0]            consume request (01 one, 11 two)
//     oCOUNT                      occupancy
// ---------------------------------------------------------------------------
interface instruction_buffer_dual_if
    import instruction_buffer_dual_pkg::*;
#(
    parameter int unsigned P_WIDTH   = IB_WIDTH,
    parameter int unsigned P_DEPTH_N = IB_DEPTH_N
) ();

    logic [1:0]         iPREVIOUS_INST_VALID;
    logic [P_WIDTH-1:0] iPREVIOUS_DATA0;
    logic [P_WIDTH-1:0] iPREVIOUS_DATA1;
    logic               oPREVIOUS_LOCK;
    logic               oPREVIOUS_FETCH_STOP;
    logic [1:0]         oNEXT_INST_VALID;
    logic [P_WIDTH-1:0] oNEXT_DATA0;
    logic [P_WIDTH-1:0] oNEXT_DATA1;
    logic [1:0]         iNEXT_READ;
    logic [P_DEPTH_N:0] oCOUNT;

    modport master (
        output iPREVIOUS_INST_VALID,
        output iPREVIOUS_DATA0,
        output iPREVIOUS_DATA1,
        output iNEXT_READ,
        input  oPREVIOUS_LOCK,
        input  oPREVIOUS_FETCH_STOP,
        input  oNEXT_INST_VALID,
        input  oNEXT_DATA0,
        input  oNEXT_DATA1,
        input  oCOUNT
    );

    modport slave (
        input  iPREVIOUS_INST_VALID,
        input  iPREVIOUS_DATA0,
        input  iPREVIOUS_DATA1,
        input  iNEXT_READ,
        output oPREVIOUS_LOCK,
        output oPREVIOUS_FETCH_STOP,
        output oNEXT_INST_VALID,
        output oNEXT_DATA0,
        output oNEXT_DATA1,
        output oCOUNT
    );

endinterface

// File: rtl/instruction_buffer_dual_ram.sv
// ---------------------------------------------------------------------------
// instruction_buffer_dual_ram
//   Plain register array holding the queue entries: two synchronous write
//   ports and two asynchronous read ports, no vendor primitive.
//   Ports
//     iCLOCK                  write clock
//     iWR0_EN/ADDR/DATA       write port 0
//     iWR1_EN/ADDR/DATA       write port 1 (wins if both hit one address;
//                             the queue never issues that)
//     iRD0_ADDR / oRD0_DATA   asynchronous read port 0
//     iRD1_ADDR / oRD1_DATA   asynchronous read port 1
// ---------------------------------------------------------------------------
module instruction_buffer_dual_ram #(
    parameter int unsigned P_WIDTH   = 102,
    parameter int unsigned P_DEPTH   = 32,
    parameter int unsigned P_DEPTH_N = 5
) (
    input  logic                 iCLOCK,
    input  logic                 iWR0_EN,
    input  logic [P_DEPTH_N-1:0] iWR0_ADDR,
    input  logic [P_WIDTH-1:0]   iWR0_DATA,
    input  logic                 iWR1_EN,
    input  logic [P_DEPTH_N-1:0] iWR1_ADDR,
    input  logic [P_WIDTH-1:0]   iWR1_DATA,
    input  logic [P_DEPTH_N-1:0] iRD0_ADDR,
    output logic [P_WIDTH-1:0]   oRD0_DATA,
    input  logic [P_DEPTH_N-1:0] iRD1_ADDR,
    output logic [P_WIDTH-1:0]   oRD1_DATA
);

    logic [P_WIDTH-1:0] mem [P_DEPTH];

    always_ff @(posedge iCLOCK) begin
        if (iWR0_EN) begin
            mem[iWR0_ADDR] <= iWR0_DATA;
        end
        if (iWR1_EN) begin
            mem[iWR1_ADDR] <= iWR1_DATA;
        end
    end

    assign oRD0_DATA = mem[iRD0_ADDR];
    assign oRD1_DATA = mem[iRD1_ADDR];

endmodule

// File: rtl/instruction_buffer_dual.sv
// ---------------------------------------------------------------------------
// instruction_buffer_dual
//   Two-wide show-ahead instruction queue between fetch and a dual decoder.
//   Accepts 0/1/2 entries per cycle (pair writes are all-or-nothing, gated by
//   a conservative lock), presents the two oldest entries, and retires 0/1/2
//   per cycle. Flush and reset empty the queue and win over same-cycle
//   traffic.
//   Ports
//     iCLOCK       clock, all state on rising edge
//     iRESET_SYNC  synchronous active-high reset
//     iFLUSH       empties the queue at the next edge
//     bus          instruction_buffer_dual_if.slave (write lanes, read
//                  request, head data, valid/lock/stop flags, count)
// ---------------------------------------------------------------------------
module instruction_buffer_dual
    import instruction_buffer_dual_pkg::*;
#(
    parameter int unsigned P_WIDTH   = IB_WIDTH,
    parameter int unsigned P_DEPTH   = IB_DEPTH,
    parameter int unsigned P_DEPTH_N = IB_DEPTH_N,
    parameter int unsigned P_STOP_TH = IB_STOP_TH
) (
    input  logic iCLOCK,
    input  logic iRESET_SYNC,
    input  logic iFLUSH,
    instruction_buffer_dual_if.slave bus
);

    localparam int unsigned CW = P_DEPTH_N + 1;

    // Lock when free slots (P_DEPTH - count) < 2, i.e. count >= P_DEPTH - 1
    localparam logic [CW-1:0] LOCK_LEVEL = CW'(P_DEPTH - 1);
    localparam logic [CW-1:0] STOP_LEVEL = CW'(P_STOP_TH);
    localparam logic [CW-1:0] ONE_ENTRY  = CW'(1);
    localparam logic [CW-1:0] TWO_ENTRY  = CW'(2);

    logic [P_DEPTH_N-1:0] wp;
    logic [P_DEPTH_N-1:0] rp;
    logic [CW-1:0]        count;

    logic [P_DEPTH_N-1:0] wpLane1;
    logic [P_DEPTH_N-1:0] rpLane1;
    logic                 lock;
    logic                 clearAll;
    logic [1:0]           wrN;
    logic [1:0]           rdN;
    logic [CW-1:0]        countNext;
    logic                 wrEn0;
    logic                 wrEn1;

    assign clearAll = iRESET_SYNC || iFLUSH;
    assign wpLane1  = wp + P_DEPTH_N'(1);
    assign rpLane1  = rp + P_DEPTH_N'(1);

    // Flags depend only on the registered count, so they move only at edges
    // and a same-cycle read never releases the lock early.
    assign lock = (count >= LOCK_LEVEL);

    always_comb begin
        wrN = 2'd0;
        if (!lock) begin
            wrN = lane_count(bus.iPREVIOUS_INST_VALID);
        end
    end

    // Read requests are clipped to what is actually valid.
    always_comb begin
        rdN = 2'd0;
        if ((bus.iNEXT_READ == LANES_TWO) && (count >= TWO_ENTRY)) begin
            rdN = 2'd2;
        end else if (bus.iNEXT_READ[0] && (count >= ONE_ENTRY)) begin
            rdN = 2'd1;
        end
    end

    assign countNext = count + CW'(wrN) - CW'(rdN);

    // Storage is also gated on clear so a flushed write leaves no trace.
    assign wrEn0 = !clearAll && (wrN != 2'd0);
    assign wrEn1 = !clearAll && (wrN == 2'd2);

    always_ff @(posedge iCLOCK) begin
        if (clearAll) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + P_DEPTH_N'(wrN);
            rp    <= rp + P_DEPTH_N'(rdN);
            count <= countNext;
        end
    end

    instruction_buffer_dual_ram #(
        .P_WIDTH   (P_WIDTH),
        .P_DEPTH   (P_DEPTH),
        .P_DEPTH_N (P_DEPTH_N)
    ) u_ram (
        .iCLOCK    (iCLOCK),
        .iWR0_EN   (wrEn0),
        .iWR0_ADDR (wp),
        .iWR0_DATA (bus.iPREVIOUS_DATA0),
        .iWR1_EN   (wrEn1),
        .iWR1_ADDR (wpLane1),
        .iWR1_DATA (bus.iPREVIOUS_DATA1),
        .iRD0_ADDR (rp),
        .oRD0_DATA (bus.oNEXT_DATA0),
        .iRD1_ADDR (rpLane1),
        .oRD1_DATA (bus.oNEXT_DATA1)
    );

    assign bus.oPREVIOUS_LOCK       = lock;
    assign bus.oPREVIOUS_FETCH_STOP = (count > STOP_LEVEL);
    assign bus.oNEXT_INST_VALID     = {(count >= TWO_ENTRY), (count >= ONE_ENTRY)};
    assign bus.oCOUNT               = count;

endmodule
